// File: rtl/divider_rr_scheduler.sv
// Round-robin front end that shares one multi-cycle divider between NUM_REQ
// requesters and returns each result on a single tagged response channel.
module divider_rr_scheduler #(
  parameter int WIDTH       = 8,
  parameter int NUM_REQ     = 4,
  parameter int BYPASS_ZERO = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
  output logic                       div_go,
  output logic [WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic                       div_done,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder,
  input  logic                       div_dbz,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]           resp_quotient,
  output logic [WIDTH-1:0]           resp_remainder,
  output logic                       resp_dbz,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   rr_ptr, winner, ptr_nx;
  logic             found, accept, bypass_hit, done_q, done_rise;
  logic [WIDTH-1:0] op_a, op_b, sel_a, sel_b;

  // Search from rr_ptr upward, wrapping, for the first valid requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (winner == k[IDW-1:0]) begin
        sel_a = req_dividend[k*WIDTH +: WIDTH];
        sel_b = req_divisor[k*WIDTH +: WIDTH];
      end
    end
  end

  assign accept     = (state == IDLE) && found;
  assign bypass_hit = (BYPASS_ZERO != 0) && (sel_b == '0);
  assign ptr_nx     = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  // Only a fresh rising edge counts, so a done level left from the last op is ignored.
  assign done_rise  = div_done && !done_q;

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    div_go    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          state_nx          = bypass_hit ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        div_go   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (done_rise) state_nx = RESP;
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign resp_valid   = (state == RESP);
  assign busy         = (state != IDLE);
  assign div_dividend = op_a;
  assign div_divisor  = op_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      done_q         <= 1'b0;
      op_a           <= '0;
      op_b           <= '0;
      resp_id        <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_dbz       <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= div_done;
      if (accept) begin
        op_a    <= sel_a;
        op_b    <= sel_b;
        resp_id <= winner;
        rr_ptr  <= ptr_nx;
        if (bypass_hit) begin
          resp_quotient  <= '1;
          resp_remainder <= sel_a;
          resp_dbz       <= 1'b1;
        end
      end
      if (state == WAIT && done_rise) begin
        resp_quotient  <= div_quotient;
        resp_remainder <= div_remainder;
        resp_dbz       <= div_dbz;
      end
    end
  end

endmodule

// File: tb/tb_divider_rr_scheduler.sv
// Scoreboard bench: per-requester expected-result queues filled at stimulus time,
// a behavioural divider with sticky/stale done, and a decoupled response monitor.
module tb_divider_rr_scheduler;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_dividend = '0;
  logic [N*W-1:0] req_divisor = '0;
  logic           div_go;
  logic [W-1:0]   div_dividend, div_divisor;
  logic           div_done = 1'b0;
  logic [W-1:0]   div_quotient = '0;
  logic [W-1:0]   div_remainder = '0;
  logic           div_dbz = 1'b0;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [IDW-1:0] resp_id;
  logic [W-1:0]   resp_quotient, resp_remainder;
  logic           resp_dbz;
  logic           busy;

  divider_rr_scheduler #(.WIDTH(W), .NUM_REQ(N), .BYPASS_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_dbz(div_dbz),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder), .resp_dbz(resp_dbz),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct packed { logic [W-1:0] q; logic [W-1:0] r; logic dbz; } res_t;

  op_t  opq[N][$];
  res_t expq[N][$];
  int   idq[$];

  int tests = 0, fails = 0, go_cnt = 0, cyc = 0, last_acc_cyc = 0;
  bit chk_lat = 0, rnd_ready = 0, rnd_div = 0;
  int lat_fix = 3;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_op(int id, logic [W-1:0] a, logic [W-1:0] b);
    res_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    opq[id].push_back('{a: a, b: b});
    expq[id].push_back(e);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += opq[i].size() + expq[i].size();
    return s + ((req_valid != 0) ? 1 : 0) + idq.size();
  endfunction

  task automatic drain(string name, int limit);
    int n = 0;
    while ((pending() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < limit), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  // Behavioural divider: done is sticky until the next go, optionally staying
  // high (with the old result) for a few cycles after go before dropping.
  int   m_cnt = 0, m_stale = 0;
  bit   m_run = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      div_done <= 1'b0; m_run <= 0; m_cnt <= 0; m_stale <= 0;
    end else if (div_go) begin
      m_run   <= 1;
      m_cnt   <= rnd_div ? $urandom_range(1, 5) : lat_fix;
      m_stale <= rnd_div ? $urandom_range(1, 3) : 0;
      if (!rnd_div) div_done <= 1'b0;
    end else if (m_run) begin
      if (m_stale != 0) begin
        m_stale <= m_stale - 1;
        if (m_stale == 1) div_done <= 1'b0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else begin
        m_run    <= 0;
        div_done <= 1'b1;
        if (div_divisor == 0) begin
          div_quotient <= '1; div_remainder <= div_dividend; div_dbz <= 1'b1;
        end else begin
          div_quotient  <= div_dividend / div_divisor;
          div_remainder <= div_dividend % div_divisor;
          div_dbz       <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) resp_ready = ($urandom_range(0, 3) != 0);
  end

  // Requester driver: each requester holds its next op until valid&ready.
  always begin
    logic [N-1:0] acc;
    op_t o;
    @(negedge clk);
    acc = req_valid & req_ready;
    if (acc != 0) last_acc_cyc = cyc;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] || !req_valid[i]) begin
        if (opq[i].size() > 0) begin
          o = opq[i].pop_front();
          req_valid[i] = 1'b1;
          req_dividend[i*W +: W] = o.a;
          req_divisor[i*W +: W]  = o.b;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  bit prev_rv = 0;
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      prev_rv = 0;
    end else begin
      if (div_go) go_cnt++;
      if (resp_valid) begin
        check("req_ready_in_resp", 64'(req_ready), 64'd0);
        check("go_in_resp", 64'(div_go), 64'd0);
        if (chk_lat && !prev_rv) check("bypass_latency", 64'(cyc - last_acc_cyc), 64'd1);
        if (expq[resp_id].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got id %0d expected none", resp_id);
        end else begin
          e = expq[resp_id][0];
          check("resp_quotient", 64'(resp_quotient), 64'(e.q));
          check("resp_remainder", 64'(resp_remainder), 64'(e.r));
          check("resp_dbz", 64'(resp_dbz), 64'(e.dbz));
          if (resp_ready) begin
            void'(expq[resp_id].pop_front());
            if (idq.size() > 0) check("resp_id_order", 64'(resp_id), 64'(idq.pop_front()));
          end
        end
      end
      prev_rv = resp_valid;
    end
  end

  initial begin
    int g0, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({req_ready, div_go, div_dividend, div_divisor, resp_valid, resp_id,
               resp_quotient, resp_remainder, resp_dbz, busy}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Fairness: all four continuously valid.
    push_op(0, 8'd100, 8'd7);  push_op(0, 8'd250, 8'd16);
    push_op(1, 8'd37, 8'd5);   push_op(1, 8'd9, 8'd200);
    push_op(2, 8'd255, 8'd255);
    push_op(3, 8'd13, 8'd1);
    idq = '{0, 1, 2, 3, 0, 1};
    drain("t2_drain", 500);

    // Single request, one go pulse.
    g0 = go_cnt;
    push_op(0, 8'd200, 8'd7);
    idq.push_back(0);
    drain("t1_drain", 200);
    check("t1_go_count", 64'(go_cnt - g0), 64'd1);

    // Zero-divisor bypass.
    g0 = go_cnt;
    chk_lat = 1;
    push_op(2, 8'd77, 8'd0);
    idq.push_back(2);
    drain("t3_drain", 200);
    chk_lat = 0;
    check("t3_go_count", 64'(go_cnt - g0), 64'd0);

    // Response back-pressure for 10 cycles.
    resp_ready = 1'b0;
    push_op(3, 8'd50, 8'd6);
    push_op(1, 8'd9, 8'd4);
    idq.push_back(3); idq.push_back(1);
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    check("t4_resp_seen", 64'(resp_valid), 64'd1);
    g0 = go_cnt;
    repeat (10) @(negedge clk);
    check("t4_no_go", 64'(go_cnt - g0), 64'd0);
    check("t4_still_valid", 64'(resp_valid), 64'd1);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    drain("t4_drain", 200);

    // Reset during WAIT aborts the op and clears rr_ptr.
    lat_fix = 20;
    push_op(2, 8'd60, 8'd7);
    n = 0;
    while (!div_go && n < 100) begin @(negedge clk); n++; end
    check("t5_go_seen", 64'(div_go), 64'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_reset_outputs",
          64'({req_ready, div_go, div_dividend, div_divisor, resp_valid, resp_id,
               resp_quotient, resp_remainder, resp_dbz, busy}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N; i++) expq[i].delete();
    lat_fix = 3;
    push_op(1, 8'd100, 8'd9);
    push_op(3, 8'd5, 8'd5);
    idq.push_back(1); idq.push_back(3);
    drain("t5_drain", 300);

    // Long random run with stale done levels and random back-pressure.
    rnd_div = 1;
    rnd_ready = 1;
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      push_op($urandom_range(0, N - 1), a, b);
    end
    drain("t6_drain", 60000);
    rnd_ready = 0;
    rnd_div = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
